// File: rtl/stdp_synapse_array.sv
// Plastic synapse array: saturating weighted current to the post neuron plus online pair-STDP weight updates.
// Optional macro WEIGHT_DECAY_EN adds a periodic one-step drift of every idle weight back toward W_INIT.
module stdp_synapse_array #(
    parameter int N_SYN        = 5,
    parameter int W_WIDTH      = 8,
    parameter int TRACE_WIDTH  = 4,
    parameter int W_INIT       = 32,
    parameter int W_MAX        = 255,
    parameter int DECAY_PERIOD = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       learn_en,
    input  logic [N_SYN-1:0]           pre_spike,
    input  logic                       post_spike,
    output logic [W_WIDTH-1:0]         current_out,
    output logic [N_SYN*W_WIDTH-1:0]   weights,
    output logic                       update_pulse
);

    localparam int SUM_W = W_WIDTH + 3;
    localparam int SW    = W_WIDTH + 2;

    localparam logic [TRACE_WIDTH-1:0] TRACE_MAX = '1;
    localparam logic [W_WIDTH-1:0]     W_INIT_V  = W_INIT[W_WIDTH-1:0];
    localparam logic [W_WIDTH-1:0]     W_MAX_V   = W_MAX[W_WIDTH-1:0];
    localparam logic signed [SW-1:0]   W_MAX_S   = $signed({2'b00, W_MAX_V});
    localparam logic [SUM_W-1:0]       CUR_SAT   = {3'b000, {W_WIDTH{1'b1}}};

    if (W_MAX > (2**W_WIDTH) - 1) begin : g_bad_wmax
        $error("W_MAX does not fit in W_WIDTH bits");
    end
    if (DECAY_PERIOD < 1) begin : g_bad_period
        $error("DECAY_PERIOD must be at least 1");
    end

    logic [W_WIDTH-1:0]     r_weight     [N_SYN];
    logic [TRACE_WIDTH-1:0] r_pre_trace  [N_SYN];
    logic [TRACE_WIDTH-1:0] r_post_trace;
    logic [W_WIDTH-1:0]     r_current;
    logic                   r_update;

    logic [SUM_W-1:0]       w_sum;
    logic [W_WIDTH-1:0]     w_current_next;
    logic [TRACE_WIDTH-1:0] w_ltp            [N_SYN];
    logic [TRACE_WIDTH-1:0] w_ltd            [N_SYN];
    logic signed [SW-1:0]   w_stdp_sum       [N_SYN];
    logic [W_WIDTH-1:0]     w_stdp_weight    [N_SYN];
    logic [W_WIDTH-1:0]     w_weight_next    [N_SYN];
    logic [TRACE_WIDTH-1:0] w_pre_trace_next [N_SYN];
    logic [TRACE_WIDTH-1:0] w_post_trace_next;
    logic                   w_any_change;
    logic                   w_decay_tick;

`ifdef WEIGHT_DECAY_EN
    localparam int CNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    logic [CNT_W-1:0] r_decay_cnt;

    assign w_decay_tick = (r_decay_cnt == CNT_W'(DECAY_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_decay_cnt <= '0;
        end else if (en) begin
            r_decay_cnt <= w_decay_tick ? '0 : r_decay_cnt + 1'b1;
        end
    end
`else
    assign w_decay_tick = 1'b0;
`endif

    // Input current: sum of the pre-edge weights of every synapse that spiked, clipped to the output range.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (pre_spike[i]) begin
                w_sum = w_sum + SUM_W'(r_weight[i]);
            end
        end
        w_current_next = (w_sum > CUR_SAT) ? {W_WIDTH{1'b1}} : w_sum[W_WIDTH-1:0];
    end

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        w_any_change = 1'b0;
        for (int i = 0; i < N_SYN; i++) begin
            w_ltp[i] = (learn_en && post_spike)   ? r_pre_trace[i] : '0;
            w_ltd[i] = (learn_en && pre_spike[i]) ? r_post_trace   : '0;

            w_stdp_sum[i] = $signed({2'b00, r_weight[i]})
                          + $signed({{(SW-TRACE_WIDTH){1'b0}}, w_ltp[i]})
                          - $signed({{(SW-TRACE_WIDTH){1'b0}}, w_ltd[i]});

            if (w_stdp_sum[i][SW-1]) begin
                w_stdp_weight[i] = '0;
            end else if (w_stdp_sum[i] > W_MAX_S) begin
                w_stdp_weight[i] = W_MAX_V;
            end else begin
                w_stdp_weight[i] = w_stdp_sum[i][W_WIDTH-1:0];
            end

            // Decay only touches synapses that STDP left alone this cycle.
            w_weight_next[i] = w_stdp_weight[i];
            if (w_decay_tick && learn_en && (w_stdp_weight[i] == r_weight[i])) begin
                if (r_weight[i] > W_INIT_V) begin
                    w_weight_next[i] = r_weight[i] - 1'b1;
                end else if (r_weight[i] < W_INIT_V) begin
                    w_weight_next[i] = r_weight[i] + 1'b1;
                end
            end

            if (w_weight_next[i] != r_weight[i]) begin
                w_any_change = 1'b1;
            end

            if (pre_spike[i]) begin
                w_pre_trace_next[i] = TRACE_MAX;
            end else if (r_pre_trace[i] != '0) begin
                w_pre_trace_next[i] = r_pre_trace[i] - 1'b1;
            end else begin
                w_pre_trace_next[i] = '0;
            end
        end
    end

    always_comb begin
        if (post_spike) begin
            w_post_trace_next = TRACE_MAX;
        end else if (r_post_trace != '0) begin
            w_post_trace_next = r_post_trace - 1'b1;
        end else begin
            w_post_trace_next = '0;
        end
    end

    // NOTE: weights are flops rather than a RAM, so every entry takes the async reset to W_INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SYN; i++) begin
                r_weight[i]    <= W_INIT_V;
                r_pre_trace[i] <= '0;
            end
            r_post_trace <= '0;
            r_current    <= '0;
            r_update     <= 1'b0;
        end else if (en) begin
            for (int i = 0; i < N_SYN; i++) begin
                r_weight[i]    <= w_weight_next[i];
                r_pre_trace[i] <= w_pre_trace_next[i];
            end
            r_post_trace <= w_post_trace_next;
            r_current    <= w_current_next;
            r_update     <= w_any_change;
        end else begin
            r_current <= '0;
            r_update  <= 1'b0;
        end
    end

    for (genvar g = 0; g < N_SYN; g++) begin : g_flat
        assign weights[g*W_WIDTH +: W_WIDTH] = r_weight[g];
    end

    assign current_out  = r_current;
    assign update_pulse = r_update;

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Scoreboard bench for stdp_synapse_array: a per-cycle reference model queues expected outputs,
// and a monitor pops and compares them one edge later.
module tb_stdp_synapse_array;

    localparam int N_SYN = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        learn_en;
    logic [4:0]  pre_spike;
    logic        post_spike;
    logic [7:0]  current_out;
    logic [39:0] weights;
    logic        update_pulse;

    stdp_synapse_array dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .learn_en     (learn_en),
        .pre_spike    (pre_spike),
        .post_spike   (post_spike),
        .current_out  (current_out),
        .weights      (weights),
        .update_pulse (update_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cur;
        logic [39:0] w;
        logic        upd;
    } exp_t;

    exp_t exp_q[$];

    int m_w[N_SYN];
    int m_pre[N_SYN];
    int m_post;
    int m_cnt;
    int n_checks = 0;
    int n_pass   = 0;
    int n_cycle  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, n_cycle, act, req);
    endtask

    function automatic logic [39:0] pack_model();
        logic [39:0] v;
        for (int i = 0; i < N_SYN; i++) v[i*8 +: 8] = 8'(m_w[i]);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_SYN; i++) begin
            m_w[i]   = 32;
            m_pre[i] = 0;
        end
        m_post = 0;
        m_cnt  = 0;
    endfunction

    // Reference model: integer arithmetic straight from the synapse rules.
    function automatic void model_step(input bit e, input bit l, input bit [4:0] p, input bit q);
        exp_t x;
        int   sum;
        int   nw[N_SYN];
        bit   chg;
        sum = 0;
        chg = 0;
        if (!e) begin
            x.cur = 8'd0;
            x.upd = 1'b0;
        end else begin
            for (int i = 0; i < N_SYN; i++) if (p[i]) sum += m_w[i];
            x.cur = 8'((sum > 255) ? 255 : sum);
            for (int i = 0; i < N_SYN; i++) begin
                int v;
                v = m_w[i] + ((l && q) ? m_pre[i] : 0) - ((l && p[i]) ? m_post : 0);
                nw[i] = (v < 0) ? 0 : ((v > 255) ? 255 : v);
`ifdef WEIGHT_DECAY_EN
                if (m_cnt == 63 && l && nw[i] == m_w[i]) begin
                    if (m_w[i] > 32) nw[i] = m_w[i] - 1;
                    else if (m_w[i] < 32) nw[i] = m_w[i] + 1;
                end
`endif
                if (nw[i] != m_w[i]) chg = 1;
            end
`ifdef WEIGHT_DECAY_EN
            m_cnt = (m_cnt == 63) ? 0 : m_cnt + 1;
`endif
            for (int i = 0; i < N_SYN; i++) begin
                m_w[i]   = nw[i];
                m_pre[i] = p[i] ? 15 : ((m_pre[i] > 0) ? m_pre[i] - 1 : 0);
            end
            m_post = q ? 15 : ((m_post > 0) ? m_post - 1 : 0);
            x.upd  = chg;
        end
        x.w = pack_model();
        exp_q.push_back(x);
    endfunction

    // Monitor: one expectation per stimulated edge, compared 1 time unit after that edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                check("current_out", 64'(current_out), 64'(x.cur));
                check("weights", 64'(weights), 64'(x.w));
                check("update_pulse", 64'(update_pulse), 64'(x.upd));
                n_cycle++;
            end
        end
    end

    task automatic step(input bit e, input bit l, input bit [4:0] p, input bit q);
        @(negedge clk);
        en         = e;
        learn_en   = l;
        pre_spike  = p;
        post_spike = q;
        model_step(e, l, p, q);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 1, 5'b00000, 1'b0);
    endtask

    task automatic random_steps(input int n);
        repeat (n) begin
            bit [4:0] p;
            for (int b = 0; b < N_SYN; b++) p[b] = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, p, $urandom_range(0, 7) == 0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_weights"}, 64'(weights), 64'({5{8'd32}}));
        check({tag, "_current"}, 64'(current_out), 64'd0);
        check({tag, "_update"}, 64'(update_pulse), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        learn_en   = 1'b0;
        pre_spike  = '0;
        post_spike = 1'b0;
        model_reset();
        #2;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // Current path with learning off.
        step(1, 0, 5'b00011, 0);
        check("cur_two_syn", 64'(current_out), 64'd64);
        step(1, 0, 5'b00000, 0);
        check("cur_back_to_0", 64'(current_out), 64'd0);
        check("cur_no_update", 64'(update_pulse), 64'd0);

        // LTP: pre at t, post at t+3 -> +13.
        idle(16);
        step(1, 1, 5'b00001, 0);
        idle(2);
        step(1, 1, 5'b00000, 1);
        check("ltp_w0", 64'(weights[7:0]), 64'd45);
        check("ltp_pulse", 64'(update_pulse), 64'd1);

        // LTD: post at t, pre[2] at t+5 -> -11, current uses old weight.
        idle(16);
        step(1, 1, 5'b00000, 1);
        idle(4);
        step(1, 1, 5'b00100, 0);
        check("ltd_w2", 64'(weights[23:16]), 64'd21);
        check("ltd_cur_old_w", 64'(current_out), 64'd32);

        // Saturation high on every synapse.
        idle(16);
        repeat (16) begin
            step(1, 1, 5'b11111, 0);
            step(1, 1, 5'b00000, 1);
            idle(16);
        end
        check("sat_w0", 64'(weights[7:0]), 64'd255);
        step(1, 1, 5'b00001, 0);
        step(1, 1, 5'b00000, 1);
        check("sat_w0_hold", 64'(weights[7:0]), 64'd255);
        check("sat_no_pulse", 64'(update_pulse), 64'd0);
        idle(16);
        step(1, 0, 5'b11111, 0);
        check("sat_current", 64'(current_out), 64'd255);

        // LTD clamp at 0 on synapse 4.
        idle(16);
        repeat (20) begin
            step(1, 1, 5'b00000, 1);
            step(1, 1, 5'b10000, 0);
            idle(16);
        end
        check("ltd_clamp_w4", 64'(weights[39:32]), 64'd0);

        // Freeze with en low, then coincident pre/post with empty traces.
        step(0, 1, 5'b11111, 1);
        check("freeze_current", 64'(current_out), 64'd0);
        check("freeze_update", 64'(update_pulse), 64'd0);
        step(0, 1, 5'b01010, 1);
        idle(16);
        step(1, 1, 5'b00010, 1);
        check("coincident_w1", 64'(weights[15:8]), 64'd255);

        // Random traffic against the model.
        random_steps(400);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        step(1, 0, 5'b00011, 0);
        check("post_rst_cur", 64'(current_out), 64'd64);
        random_steps(200);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
